mem_wait_ram: RTL and testbench

- Parametrised, size-aware data memory with a req/ready handshake and programmable wait states.
- Successor to the fixed combinational RAM model that sits on the CPU memory bus. It lets the CPU be run against slow memory.
- Adds error reporting for misaligned and out-of-range accesses, and signed/unsigned sub-word loads.
- Width, depth and latency are parameters; little-endian byte order.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 64 ++++++
 rtl/mem_wait_ram.sv | 218 +++++++++++++++++++++
 tb/tb_mem_wait_ram.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the wait-state data memory.
// Size encodings, FSM states and byte-lane mask helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } mem_state_e;

  // Byte-enable mask for an access of a given size at a lane offset.
  function automatic logic [7:0] lane_mask(
    input logic [1:0] size,
    input logic [2:0] off
  );
    logic [7:0] base;
    unique case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0f;
      default: base = 8'hff;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane extract/extend for loads, shift/mask for stores.
// Purely combinational; little-endian lane order.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] rd_word_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [DATA_W-1:0] wr_word_o,
  output logic [NB-1:0]     wr_mask_o
);

  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] hi_m;
  logic              sgn;
  logic [7:0]        m8;

  // Right-align the addressed lanes, then sign/zero-extend above them.
  always_comb begin
    sh   = rd_word_i >> {off_i, 3'b000};
    hi_m = '0;
    sgn  = 1'b0;
    unique case (size_i)
      SZ_BYTE: begin
        hi_m = ONES << 8;
        sgn  = sh[7];
      end
      SZ_HALF: begin
        hi_m = ONES << 16;
        sgn  = sh[15];
      end
      SZ_WORD: begin
        hi_m = (DATA_W > 32) ? (ONES << 32) : '0;
        sgn  = sh[31];
      end
      default: begin
        hi_m = '0;
        sgn  = 1'b0;
      end
    endcase
    if (sgn && !uns_i) begin
      rd_data_o = sh | hi_m;
    end else begin
      rd_data_o = sh & ~hi_m;
    end
  end

  // Move store data into its lanes and build the byte enables.
  always_comb begin
    wr_word_o = wr_data_i << {off_i, 3'b000};
    m8        = lane_mask(size_i, 3'(off_i));
    wr_mask_o = NB'(m8);
  end

endmodule

// File: rtl/mem_wait_ram.sv
// Data memory with req/ready handshake and wait states.
// Reports misaligned/out-of-range accesses via err.
module mem_wait_ram
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 0
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        mem_size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] RD_L = 4'(RD_LAT);
  localparam logic [3:0] WR_L = 4'(WR_LAT);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              acc_mis;
  logic              acc_oor;
  logic              acc_err;
  logic [3:0]        acc_lat;
  logic              imm;
  logic              dfr;
  logic              ex_go;
  logic              ex_we;
  logic              ex_err;
  logic [1:0]        ex_size;
  logic              ex_uns;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic [MIDX_W-1:0] ex_idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] wr_word;
  logic [NB-1:0]     wr_mask;
  logic              mem_we;

  // Accept-time checks: alignment, illegal size, word range.
  always_comb begin
    acc_mis = 1'b0;
    unique case (mem_size)
      SZ_BYTE:   acc_mis = 1'b0;
      SZ_HALF:   acc_mis = addr[0];
      SZ_WORD:   acc_mis = |addr[1:0];
      default:   acc_mis = (DATA_W == 32) || (|addr[2:0]);
    endcase
    acc_oor = (addr >> OFF_W) >= ADDR_W'(DEPTH);
    acc_err = acc_mis | acc_oor;
  end

  assign accept  = req && (state_q == ST_IDLE || state_q == ST_RESP);
  assign acc_lat = we ? WR_L : RD_L;

  // Zero latency and rejected accesses complete on the accept edge;
  // everything else completes when the wait counter runs out.
  assign imm   = accept && (acc_err || acc_lat == 4'd0);
  assign dfr   = (state_q == ST_WAIT) && (cnt_q == 4'd1);
  assign ex_go = reset && (imm || dfr);

  // Operands come straight from the bus for an immediate access.
  always_comb begin
    if (imm) begin
      ex_we    = we;
      ex_size  = mem_size;
      ex_uns   = load_unsigned;
      ex_addr  = addr;
      ex_wdata = data_i;
      ex_err   = acc_err;
    end else begin
      ex_we    = we_q;
      ex_size  = size_q;
      ex_uns   = uns_q;
      ex_addr  = addr_q;
      ex_wdata = wdata_q;
      ex_err   = 1'b0;
    end
  end

  assign ex_idx  = MIDX_W'(ex_addr >> OFF_W);
  assign rd_word = mem_q[ex_idx];
  assign mem_we  = ex_go && !ex_err && ex_we;

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size_i    (ex_size),
    .uns_i     (ex_uns),
    .off_i     (ex_addr[OFF_W-1:0]),
    .rd_word_i (rd_word),
    .wr_data_i (ex_wdata),
    .rd_data_o (rd_data),
    .wr_word_o (wr_word),
    .wr_mask_o (wr_mask)
  );

  // Byte-lane write; contents survive reset.
  always_ff @(posedge mem_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_we && wr_mask[b]) begin
        mem_q[ex_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  // Next state, wait counter, request latch and response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          we_d    = we;
          size_d  = mem_size;
          uns_d   = load_unsigned;
          addr_d  = addr;
          wdata_d = data_i;
          if (imm) begin
            state_d = ST_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = acc_lat;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    ready_d = ex_go;
    err_d   = ex_go && ex_err;
    data_d  = data_q;
    if (ex_go) begin
      if (ex_err) begin
        data_d = '0;
      end else if (!ex_we) begin
        data_d = rd_data;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge mem_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign data_o = data_q;
  assign ready  = ready_q;
  assign err    = err_q;
  assign busy   = (state_q == ST_WAIT) ||
                  (state_q == ST_RESP && !accept);

endmodule

// File: tb/tb_mem_wait_ram.sv
// Scoreboard bench for mem_wait_ram: two instances with
// different latencies checked against a byte-array model.
module tb_mem_wait_ram;

  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req   [2];
  logic        we    [2];
  logic [1:0]  sz    [2];
  logic        uns   [2];
  logic [31:0] addr  [2];
  logic [31:0] din   [2];
  logic [31:0] dout  [2];
  logic        rdy   [2];
  logic        err   [2];
  logic        busy  [2];

  always #5 clk = ~clk;

  mem_wait_ram #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .RD_LAT(3), .WR_LAT(0)
  ) dut0 (
    .mem_clk(clk), .reset(rst_n[0]), .req(req[0]),
    .we(we[0]), .mem_size(sz[0]),
    .load_unsigned(uns[0]), .addr(addr[0]),
    .data_i(din[0]), .data_o(dout[0]),
    .ready(rdy[0]), .err(err[0]), .busy(busy[0])
  );

  mem_wait_ram #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH),
    .RD_LAT(0), .WR_LAT(5)
  ) dut1 (
    .mem_clk(clk), .reset(rst_n[1]), .req(req[1]),
    .we(we[1]), .mem_size(sz[1]),
    .load_unsigned(uns[1]), .addr(addr[1]),
    .data_i(din[1]), .data_o(dout[1]),
    .ready(rdy[1]), .err(err[1]), .busy(busy[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          edge_n;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [7:0]  mm [2][NBYTES];
  logic [31:0] last_d [2];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, expv);
  endtask

  function automatic int lat_of(input int s, input logic w);
    if (s == 0) return w ? 0 : 3;
    return w ? 5 : 0;
  endfunction

  // Reference model: byte-addressed little-endian memory.
  task automatic model(input int s, input logic w,
                       input logic [1:0] z, input logic u,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       output logic e,
                       output logic [31:0] r);
    int n;
    logic [31:0] v;
    n = 1 << z;
    e = (z == 2'd3) || ((a % n) != 0) ||
        ((a / 4) >= DEPTH);
    r = 32'h0;
    if (e) begin
      last_d[s] = 32'h0;
    end else if (w) begin
      for (int k = 0; k < n; k++)
        mm[s][a + k] = d[8*k +: 8];
      r = last_d[s];
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++)
        v = v | (32'(mm[s][a + k]) << (8 * k));
      if (!u && n < 4 && v[8*n-1])
        v = v | ~((32'd1 << (8 * n)) - 32'd1);
      r = v;
      last_d[s] = v;
    end
  endtask

  task automatic issue(input int s, input logic w,
                       input logic [1:0] z, input logic u,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input bit hold);
    logic e;
    logic [31:0] r;
    exp_t x;
    int n;
    @(negedge clk);
    req[s] = 1'b1; we[s] = w; sz[s] = z;
    uns[s] = u; addr[s] = a; din[s] = d;
    #1;
    n = 0;
    while (busy[s] && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 100) chk("accept timeout", 64'(busy[s]), 0);
    model(s, w, z, u, a, d, e, r);
    x.data   = r;
    x.err    = e;
    x.edge_n = cyc + 1 + (e ? 0 : lat_of(s, w));
    if (s == 0) q0.push_back(x);
    else q1.push_back(x);
    @(posedge clk); #1;
    if (!hold) req[s] = 1'b0;
  endtask

  task automatic drain(input int s);
    int n;
    n = 0;
    while (((s == 0) ? q0.size() : q1.size()) != 0 &&
           n < 60) begin
      @(negedge clk); n++;
    end
    if (n >= 60)
      chk("drain timeout",
          64'((s == 0) ? q0.size() : q1.size()), 0);
    @(negedge clk);
  endtask

  // Monitor: every ready pulse must match the queue head.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst_n[s] && rdy[s]) begin
        exp_t x;
        int   qs;
        qs = (s == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          chk($sformatf("d%0d spurious ready", s),
              64'(rdy[s]), 0);
        end else begin
          if (s == 0) x = q0.pop_front();
          else x = q1.pop_front();
          chk($sformatf("d%0d data", s),
              64'(dout[s]), 64'(x.data));
          chk($sformatf("d%0d err", s),
              64'(err[s]), 64'(x.err));
          chk($sformatf("d%0d ready cycle", s),
              64'(cyc), 64'(x.edge_n));
        end
      end
    end
  end

  task automatic rand_ops(input int s, input int cnt);
    logic [1:0] z;
    logic [31:0] a;
    int n;
    for (int i = 0; i < cnt; i++) begin
      z = 2'($urandom_range(0, 3));
      n = 1 << z;
      a = $urandom_range(0, NBYTES + 15);
      if ($urandom_range(0, 3) != 0)
        a = a & ~(32'(n) - 32'd1);
      issue(s, 1'($urandom_range(0, 1)), z,
            1'($urandom_range(0, 1)), a, $urandom, 0);
    end
    drain(s);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int spur;
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; req[s] = 1'b0; we[s] = 1'b0;
      sz[s] = 2'b00; uns[s] = 1'b0;
      addr[s] = 32'h0; din[s] = 32'h0;
      last_d[s] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset data_o", 64'(dout[s]), 0);
      chk("reset ready", 64'(rdy[s]), 0);
      chk("reset err", 64'(err[s]), 0);
      chk("reset busy", 64'(busy[s]), 0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < DEPTH; w++)
        issue(s, 1, 2'b10, 0, 32'(w * 4),
              $urandom | 32'h1, 0);
    drain(0);
    drain(1);

    issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    drain(0);
    chk("ld word", 64'(dout[0]), 64'h0DEADBEEF);
    issue(0, 0, 2'b00, 0, 32'h13, 32'h0, 0);
    drain(0);
    chk("ld byte s", 64'(dout[0]), 64'h0FFFFFFDE);
    issue(0, 0, 2'b00, 1, 32'h13, 32'h0, 0);
    drain(0);
    chk("ld byte u", 64'(dout[0]), 64'h0000000DE);
    issue(0, 0, 2'b01, 0, 32'h10, 32'h0, 0);
    drain(0);
    chk("ld half s", 64'(dout[0]), 64'h0FFFFBEEF);
    issue(0, 1, 2'b00, 0, 32'h11, 32'h55, 0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    drain(0);
    chk("ld merged", 64'(dout[0]), 64'h0DEAD55EF);

    issue(0, 0, 2'b01, 0, 32'h21, 32'h0, 0);
    issue(0, 1, 2'b10, 0, 32'(NBYTES), 32'hCAFEF00D, 0);
    issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 0);
    drain(0);

    // Stray req and bus changes while a load waits.
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10;
    din[0] = 32'h0;
    chk("busy in wait", 64'(busy[0]), 1);
    @(negedge clk);
    req[0] = 1'b0; addr[0] = 32'h24;
    drain(0);
    issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    drain(0);
    chk("stray req ignored", 64'(dout[0]), 64'h0DEAD55EF);

    rand_ops(0, 150);

    issue(1, 0, 2'b10, 0, 32'h04, 32'h0, 1);
    issue(1, 0, 2'b00, 0, 32'h09, 32'h0, 1);
    issue(1, 0, 2'b01, 1, 32'h0E, 32'h0, 0);
    drain(1);

    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; sz[1] = 2'b10;
    addr[1] = 32'h40; din[1] = 32'h12345678;
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("d1 busy in wait", 64'(busy[1]), 1);
    repeat (2) @(posedge clk);
    #3;
    rst_n[1] = 1'b0;
    #1;
    chk("rst mid ready", 64'(rdy[1]), 0);
    chk("rst mid err", 64'(err[1]), 0);
    chk("rst mid data", 64'(dout[1]), 0);
    chk("rst mid busy", 64'(busy[1]), 0);
    last_d[1] = 32'h0;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    spur = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy[1]) spur++;
    end
    chk("no ready after reset", 64'(spur), 0);
    issue(1, 0, 2'b10, 0, 32'h40, 32'h0, 0);
    drain(1);

    rand_ops(1, 120);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
